// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one i2c_master between NUM_REQ requesters.
// Holds the master operands stable per transfer and returns read data or a timeout error.
module i2c_txn_arbiter #(
  parameter int unsigned NUM_REQ             = 4,
  parameter int unsigned ADDRESS_WIDTH       = 7,
  parameter int unsigned REGISTER_ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH          = 8,
  parameter int unsigned START_TIMEOUT       = 64,
  parameter int unsigned TXN_TIMEOUT         = 65535
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [15:0]                            cfg_divider,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0]                     req_rw,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]       req_dev_addr,
  input  logic [NUM_REQ*REGISTER_ADDR_WIDTH-1:0] req_reg_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]          req_wdata,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic                                   rsp_err,
  output logic [DATA_WIDTH-1:0]                  rsp_rdata,
  output logic [$clog2(NUM_REQ)-1:0]             grant_id,
  output logic                                   arb_busy,
  output logic                                   m_en,
  output logic                                   m_rw,
  output logic [ADDRESS_WIDTH-1:0]               m_device_addr,
  output logic [REGISTER_ADDR_WIDTH-1:0]         m_register_addr,
  output logic [DATA_WIDTH-1:0]                  m_mosi,
  output logic [15:0]                            m_divider,
  input  logic [DATA_WIDTH-1:0]                  m_miso,
  input  logic                                   m_busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 17;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]                     state, state_nxt;
  logic [CNT_W-1:0]               cnt, cnt_nxt;
  logic [ID_W-1:0]                ptr, winner;
  logic                           any_valid, grant;
  logic                           resp_err_nxt;
  logic [DATA_WIDTH-1:0]          resp_rdata_nxt;
  logic                           sel_rw;
  logic [ADDRESS_WIDTH-1:0]       sel_dev;
  logic [REGISTER_ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0]          sel_wdata;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && 1'(req_valid >> idx)) begin
        any_valid = 1'b1;
        winner    = ID_W'(idx);
      end
    end
  end

  assign grant     = (state == IDLE) && !m_busy && any_valid;
  assign req_ready = (grant && !reset) ? (NUM_REQ'(1'b1) << winner) : '0;

  assign sel_rw    = 1'(req_rw >> winner);
  assign sel_dev   = ADDRESS_WIDTH'(req_dev_addr >> (32'(winner) * ADDRESS_WIDTH));
  assign sel_reg   = REGISTER_ADDR_WIDTH'(req_reg_addr >> (32'(winner) * REGISTER_ADDR_WIDTH));
  assign sel_wdata = DATA_WIDTH'(req_wdata >> (32'(winner) * DATA_WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, cycle counter and the response that goes out in RESP.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    resp_err_nxt   = 1'b1;
    resp_rdata_nxt = '0;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = LAUNCH;
          cnt_nxt   = '0;
        end
      end
      LAUNCH: begin
        if (m_busy) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!m_busy) begin
          state_nxt      = RESP;
          resp_err_nxt   = 1'b0;
          resp_rdata_nxt = m_rw ? m_miso : '0;
        end else if (cnt == CNT_W'(TXN_TIMEOUT - 1)) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs; operands only move on an accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr             <= '0;
      grant_id        <= '0;
      arb_busy        <= 1'b0;
      m_en            <= 1'b0;
      m_rw            <= 1'b0;
      m_device_addr   <= '0;
      m_register_addr <= '0;
      m_mosi          <= '0;
      m_divider       <= '0;
      rsp_valid       <= '0;
      rsp_err         <= 1'b0;
      rsp_rdata       <= '0;
    end else begin
      m_en      <= (state_nxt == LAUNCH);
      arb_busy  <= (state_nxt != IDLE);
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      if (grant) begin
        grant_id        <= winner;
        ptr             <= (32'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
        m_rw            <= sel_rw;
        m_device_addr   <= sel_dev;
        m_register_addr <= sel_reg;
        m_mosi          <= sel_wdata;
        m_divider       <= cfg_divider;
      end
      if (state_nxt == RESP) begin
        rsp_valid <= NUM_REQ'(1'b1) << grant_id;
        rsp_err   <= resp_err_nxt;
        rsp_rdata <= resp_rdata_nxt;
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: arbitration table plus hand-written timeout/reset sequences.
// A second instance with a short transfer timeout covers the stuck-busy abort.
module tb_i2c_txn_arbiter;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int RW = 8;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic [15:0]   cfg_divider;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_rw;
  logic [N*AW-1:0] req_dev_addr;
  logic [N*RW-1:0] req_reg_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] m_miso;
  logic          m_busy;

  logic [N-1:0]  req_ready, rsp_valid;
  logic          rsp_err, arb_busy, m_en, m_rw;
  logic [DW-1:0] rsp_rdata, m_mosi;
  logic [1:0]    grant_id;
  logic [AW-1:0] m_device_addr;
  logic [RW-1:0] m_register_addr;
  logic [15:0]   m_divider;

  logic [N-1:0]  b_req_ready, b_rsp_valid;
  logic          b_rsp_err, b_arb_busy, b_m_en, b_m_rw;
  logic [DW-1:0] b_rsp_rdata, b_m_mosi;
  logic [1:0]    b_grant_id;
  logic [AW-1:0] b_m_device_addr;
  logic [RW-1:0] b_m_register_addr;
  logic [15:0]   b_m_divider;

  int checks = 0;
  int errors = 0;

  i2c_txn_arbiter dut (
    .clk(clk), .reset(reset), .cfg_divider(cfg_divider),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .grant_id(grant_id), .arb_busy(arb_busy), .m_en(m_en), .m_rw(m_rw),
    .m_device_addr(m_device_addr), .m_register_addr(m_register_addr),
    .m_mosi(m_mosi), .m_divider(m_divider), .m_miso(m_miso), .m_busy(m_busy)
  );

  i2c_txn_arbiter #(.TXN_TIMEOUT(100)) dut_short (
    .clk(clk), .reset(reset), .cfg_divider(cfg_divider),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
    .grant_id(b_grant_id), .arb_busy(b_arb_busy), .m_en(b_m_en), .m_rw(b_m_rw),
    .m_device_addr(b_m_device_addr), .m_register_addr(b_m_register_addr),
    .m_mosi(b_m_mosi), .m_divider(b_m_divider), .m_miso(m_miso), .m_busy(m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0]  mask;
    int            id;
    logic          rw;
    logic [DW-1:0] miso;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Distinct per-slice filler so a wrong slice select is visible.
  task automatic fill_fields();
    for (int i = 0; i < N; i++) begin
      req_dev_addr[i*AW +: AW] = AW'(32'h60 + i);
      req_reg_addr[i*RW +: RW] = RW'(32'hC0 + i);
      req_wdata[i*DW +: DW]    = DW'(32'hE0 + i);
    end
  endtask

  function automatic logic [60:0] all_out();
    return {req_ready, rsp_valid, rsp_err, rsp_rdata, grant_id, arb_busy, m_en, m_rw,
            m_device_addr, m_register_addr, m_mosi, m_divider};
  endfunction

  // One full transaction from IDLE; caller is in the low phase. Mask stays asserted.
  task automatic txn(input logic [N-1:0] mask, input int id, input logic rw,
                     input logic [AW-1:0] dev, input logic [RW-1:0] regv,
                     input logic [DW-1:0] wd, input logic [15:0] div,
                     input logic [DW-1:0] miso, input int busy_n,
                     input logic [DW-1:0] exp_rdata, input string name);
    logic [N-1:0] oh;
    logic [40:0]  ops;
    oh = N'(1) << id;
    ops = {rw, dev, regv, wd, div};
    fill_fields();
    req_dev_addr[id*AW +: AW] = dev;
    req_reg_addr[id*RW +: RW] = regv;
    req_wdata[id*DW +: DW]    = wd;
    req_rw      = rw ? 4'hF : 4'h0;
    cfg_divider = div;
    m_miso      = miso;
    m_busy      = 1'b0;
    req_valid   = mask;
    #1;
    chk($sformatf("%s ready", name), 64'(req_ready), 64'(oh));
    tick();
    chk($sformatf("%s launch_en", name), 64'(m_en), 64'd1);
    chk($sformatf("%s grant_id", name), 64'(grant_id), 64'(id));
    chk($sformatf("%s operands", name), 64'({m_rw, m_device_addr, m_register_addr, m_mosi, m_divider}), 64'(ops));
    chk($sformatf("%s ready_low", name), 64'({req_ready, arb_busy}), 64'b00001);
    fill_fields();
    cfg_divider = 16'hFFFF;
    req_rw      = ~req_rw;
    m_busy      = 1'b1;
    repeat (busy_n) tick();
    chk($sformatf("%s held", name), 64'({m_en, m_rw, m_device_addr, m_register_addr, m_mosi, m_divider}), 64'(ops));
    m_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid != '0) break;
    end
    chk($sformatf("%s rsp_valid", name), 64'(rsp_valid), 64'(oh));
    chk($sformatf("%s rsp", name), 64'({rsp_err, rsp_rdata, arb_busy}), 64'({1'b0, exp_rdata, 1'b1}));
    tick();
    chk($sformatf("%s one_pulse", name), 64'({rsp_valid, arb_busy}), 64'd0);
  endtask

  initial begin
    int en_cnt, run_cnt;
    logic [N-1:0] seen;

    tbl[0]  = '{4'b1111, 0, 1'b0, 8'h11, 8'h00};
    tbl[1]  = '{4'b1111, 1, 1'b1, 8'h22, 8'h22};
    tbl[2]  = '{4'b1111, 2, 1'b0, 8'h33, 8'h00};
    tbl[3]  = '{4'b1111, 3, 1'b1, 8'h44, 8'h44};
    tbl[4]  = '{4'b1111, 0, 1'b1, 8'h55, 8'h55};
    tbl[5]  = '{4'b1111, 1, 1'b0, 8'h66, 8'h00};
    tbl[6]  = '{4'b1111, 2, 1'b1, 8'h77, 8'h77};
    tbl[7]  = '{4'b1111, 3, 1'b0, 8'h88, 8'h00};
    tbl[8]  = '{4'b1010, 1, 1'b1, 8'h99, 8'h99};
    tbl[9]  = '{4'b1010, 3, 1'b0, 8'hAA, 8'h00};
    tbl[10] = '{4'b0100, 2, 1'b1, 8'hBB, 8'hBB};
    tbl[11] = '{4'b0011, 0, 1'b1, 8'hCC, 8'hCC};
    tbl[12] = '{4'b1001, 3, 1'b0, 8'hDD, 8'h00};

    reset = 1'b1; cfg_divider = '0; req_valid = '0; req_rw = '0;
    req_dev_addr = '0; req_reg_addr = '0; req_wdata = '0; m_miso = '0; m_busy = 1'b0;
    tick(); tick();
    chk("reset_outputs", 64'(all_out()), 64'd0);
    reset = 1'b0;
    tick();

    txn(4'b0010, 1, 1'b0, 7'h50, 8'h10, 8'hA5, 16'd100, 8'hEE, 200, 8'h00, "wr1");
    txn(4'b0100, 2, 1'b1, 7'h2A, 8'h33, 8'h5A, 16'd100, 8'h3C, 40, 8'h3C, "rd2");
    req_valid = '0;

    // No grant while the master still reports busy; a dropped request leaves no trace.
    m_busy = 1'b1; req_valid = 4'b0001;
    #1;
    chk("busy_gate_ready", 64'(req_ready), 64'd0);
    tick();
    chk("busy_gate_idle", 64'({arb_busy, m_en}), 64'd0);
    req_valid = '0; m_busy = 1'b0;
    tick();
    chk("dropped_req", 64'({req_ready, arb_busy, m_en}), 64'd0);

    reset = 1'b1; tick(); reset = 1'b0; tick();
    for (int v = 0; v < 13; v++)
      txn(tbl[v].mask, tbl[v].id, tbl[v].rw, AW'(32'h30 + v), RW'(32'h40 + v),
          DW'(32'h80 + v), 16'(10 + v), tbl[v].miso, 3 + v, tbl[v].rdata,
          $sformatf("vec%0d", v));
    req_valid = '0;

    // Master never answers en: 64 cycles of m_en then an error response.
    m_busy = 1'b0; req_valid = 4'b0001;
    #1;
    chk("start_to ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    en_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (m_en) en_cnt++;
      if (rsp_valid != '0) break;
      tick();
    end
    chk("start_to en_cycles", 64'(en_cnt), 64'd64);
    chk("start_to rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({4'b0001, 1'b1, 8'h00}));
    tick();
    chk("start_to one_pulse", 64'(rsp_valid), 64'd0);

    // Busy stuck high on the short-timeout instance.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    req_valid = 4'b1000;
    #1;
    chk("stuck ready", 64'(b_req_ready), 64'b1000);
    tick();
    m_busy = 1'b1; req_valid = 4'b0001;
    run_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (b_rsp_valid != '0) break;
      run_cnt++;
    end
    chk("stuck run_cycles", 64'(run_cnt), 64'd100);
    chk("stuck rsp", 64'({b_rsp_valid, b_rsp_err, b_rsp_rdata}), 64'({4'b1000, 1'b1, 8'h00}));
    seen = '0;
    repeat (20) begin
      tick();
      seen = seen | b_req_ready | b_rsp_valid;
    end
    chk("stuck no_grant", 64'({seen, b_arb_busy, b_m_en}), 64'd0);
    m_busy = 1'b0;
    #1;
    chk("stuck regrant", 64'(b_req_ready), 64'b0001);
    tick();
    req_valid = '0;

    // Reset in the middle of a transfer.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    req_valid = 4'b0100; m_busy = 1'b0;
    #1;
    chk("rst_mid ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0; m_busy = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("rst_mid outputs", 64'(all_out()), 64'd0);
    tick();
    reset = 1'b0; m_busy = 1'b0;
    seen = '0;
    repeat (10) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("rst_mid no_rsp", 64'(seen), 64'd0);
    txn(4'b1010, 1, 1'b1, 7'h11, 8'h22, 8'h33, 16'd7, 8'h6E, 5, 8'h6E, "rst_ptr");
    txn(4'b1000, 3, 1'b0, 7'h44, 8'h55, 8'h66, 16'd9, 8'h12, 6, 8'h00, "rst_req3");
    req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
